rv_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the FlexRV32 core: generates word-aligned fetch requests, buffers returned words in a DEPTH-entry queue and presents one aligned instruction per cycle to decode. With EXTENSION_C=1 it realigns 16- and 32-bit instructions across word boundaries. It sits between the instruction bus and `rv_decode`, and flushes and redirects on a taken branch or jump.

---
 rtl/rv_fetch_queue.sv | 116 +++++++++++
 tb/tb_rv_fetch_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: instruction-fetch front end for FlexRV32.
// Issues word-aligned bus reads, buffers returned words in a small queue and
// presents one aligned (optionally compressed) instruction per cycle to decode.
module rv_fetch_queue #(
  parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
  parameter int          DEPTH       = 4,
  parameter bit          EXTENSION_C = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_select,
  input  logic [31:0] i_pc_target,
  input  logic        i_decode_ready,
  input  logic [31:0] i_instruction,
  input  logic        i_ack,
  output logic        o_cyc,
  output logic [31:0] o_addr,
  output logic        o_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_compressed
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic          hoff;

  logic [31:0]   word0;
  logic [15:0]   word1_lo;
  logic [15:0]   half;
  logic          is32;
  logic          have;
  logic          push;
  logic          consume;
  logic          pop;

  // Head word and the low half of the word behind it (used when a 32-bit
  // instruction straddles the word boundary).
  assign word0    = mem[rd_ptr];
  assign word1_lo = mem[rd_ptr + PW'(1)][15:0];

  // Decode instruction length, validity and the presented instruction.
  always_comb begin
    half          = hoff ? word0[31:16] : word0[15:0];
    is32          = !EXTENSION_C || (half[1:0] == 2'b11);
    have          = (is32 && hoff) ? (count >= CW'(2)) : (count >= CW'(1));
    o_cyc         = !i_reset && !i_pc_select && (count < CW'(DEPTH));
    o_addr        = fetch_pc;
    o_pc          = head_pc;
    o_ready       = have && !i_pc_select && !i_reset;
    o_compressed  = 1'b0;
    o_instruction = 32'h0;
    if (o_ready) begin
      o_compressed = !is32;
      if (!is32)
        o_instruction = {16'h0, half};
      else if (hoff)
        o_instruction = {word1_lo, word0[31:16]};
      else
        o_instruction = word0;
    end
    push    = o_cyc && i_ack;
    consume = o_ready && i_decode_ready;
    // Only a 16-bit instruction in the lower half leaves the head word in place.
    pop     = consume && (is32 || hoff);
  end

  // Queue storage: written at the write pointer on every accepted bus word.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= i_instruction;
  end

  // Pointers, occupancy, fetch address and head tracking; redirect wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      hoff     <= 1'b0;
      fetch_pc <= RESET_ADDR;
      head_pc  <= RESET_ADDR;
    end else if (i_pc_select) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      hoff     <= EXTENSION_C ? i_pc_target[1] : 1'b0;
      fetch_pc <= {i_pc_target[31:2], 2'b00};
      head_pc  <= i_pc_target;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (consume) begin
        head_pc <= head_pc + (is32 ? 32'd4 : 32'd2);
        if (!is32)
          hoff <= !hoff;
      end
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: a bus model serves words from a
// small image, expected decode outputs are queued up front and compared as
// the DUT hands instructions to decode.
module tb_rv_fetch_queue;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pc_select = 1'b0;
  logic [31:0] i_pc_target = 32'h0;
  logic        i_decode_ready = 1'b0;
  logic [31:0] i_instruction = 32'h0;
  logic        i_ack = 1'b0;
  logic        o_cyc;
  logic [31:0] o_addr;
  logic        o_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        o_compressed;

  rv_fetch_queue #(
    .RESET_ADDR (32'h0000_0000),
    .DEPTH      (4),
    .EXTENSION_C(1'b1)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_pc_select   (i_pc_select),
    .i_pc_target   (i_pc_target),
    .i_decode_ready(i_decode_ready),
    .i_instruction (i_instruction),
    .i_ack         (i_ack),
    .o_cyc         (o_cyc),
    .o_addr        (o_addr),
    .o_ready       (o_ready),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .o_compressed  (o_compressed)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] img [128];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        snap_cyc;
  logic        snap_ready;
  logic [31:0] snap_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] ins, input logic c);
    exp_t e;
    e.pc = pc; e.ins = ins; e.c = c;
    sb.push_back(e);
  endtask

  // One clock cycle: serve bus data, sample away from the edge, score any
  // instruction handed to decode, then cross the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge i_clk);
    i_instruction = img[o_addr[8:2]];
    #1;
    snap_cyc   = o_cyc;
    snap_ready = o_ready;
    snap_addr  = o_addr;
    if (o_ready && i_decode_ready && !i_pc_select) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {31'b0, o_ready}, 32'h0);
      end else begin
        e = sb.pop_front();
        check("out_pc", o_pc, e.pc);
        check("out_instr", o_instruction, e.ins);
        check("out_compressed", {31'b0, o_compressed}, {31'b0, e.c});
        $display("consume pc=%08h instr=%08h c=%0d", o_pc, o_instruction, o_compressed);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_ack = 1'b0; i_decode_ready = 1'b0; i_pc_select = 1'b0; i_pc_target = 32'h0;
    @(posedge i_clk); @(posedge i_clk); #1;
    check("rst_cyc", {31'b0, o_cyc}, 32'h0);
    check("rst_ready", {31'b0, o_ready}, 32'h0);
    check("rst_pc", o_pc, 32'h0);
    check("rst_addr", o_addr, 32'h0);
    check("rst_compressed", {31'b0, o_compressed}, 32'h0);
    check("rst_instr", o_instruction, 32'h0);
    i_reset = 1'b0;
    sb.delete();
  endtask

  task automatic fill_nops();
    for (int k = 0; k < 128; k++) img[k] = 32'h0000_0013;
  endtask

  initial begin
    // Test 1: nop stream, bus acks every cycle, decode always ready.
    fill_nops();
    do_reset();
    i_ack = 1'b1; i_decode_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_out(32'(4 * k), 32'h0000_0013, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_addr", snap_addr, 32'(4 * k));
      check("t1_cyc", {31'b0, snap_cyc}, 32'h1);
      if (k == 0) check("t1_ready_c1", {31'b0, snap_ready}, 32'h0);
      if (k >= 1) check("t1_ready_stream", {31'b0, snap_ready}, 32'h1);
    end
    i_ack = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("t1_sb_empty", sb.size(), 32'h0);

    // Test 2: decode stalled fills the queue, extra acks ignored, then drain.
    fill_nops();
    for (int k = 0; k < 4; k++) img[k] = 32'h0000_0013 + (k << 20);
    do_reset();
    i_ack = 1'b1; i_decode_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      check("t2_full_cyc", {31'b0, snap_cyc}, 32'h0);
      check("t2_full_ready", {31'b0, snap_ready}, 32'h1);
      check("t2_full_addr", snap_addr, 32'h10);
    end
    i_ack = 1'b0; i_decode_ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_out(32'(4 * k), 32'h0000_0013 + (k << 20), 1'b0);
    tick();
    tick();
    check("t2_cyc_after_pop", {31'b0, snap_cyc}, 32'h1);
    tick(); tick(); tick();
    check("t2_drained_ready", {31'b0, snap_ready}, 32'h0);
    check("t2_addr_after", snap_addr, 32'h10);
    check("t2_sb_empty", sb.size(), 32'h0);

    // Test 3: two compressed instructions in one word, then a 32-bit one.
    fill_nops();
    img[0] = 32'h4501_4505; img[1] = 32'h0000_0013;
    do_reset();
    expect_out(32'h0, 32'h0000_4505, 1'b1);
    expect_out(32'h2, 32'h0000_4501, 1'b1);
    expect_out(32'h4, 32'h0000_0013, 1'b0);
    i_ack = 1'b1; i_decode_ready = 1'b1;
    tick(); tick();
    i_ack = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t3_sb_empty", sb.size(), 32'h0);

    // Test 4: 32-bit instruction straddling a word boundary.
    fill_nops();
    img[0] = 32'h0293_4505; img[1] = 32'h0000_0000;
    do_reset();
    expect_out(32'h0, 32'h0000_4505, 1'b1);
    expect_out(32'h2, 32'h0000_0293, 1'b0);
    expect_out(32'h6, 32'h0000_0000, 1'b1);
    i_ack = 1'b1; i_decode_ready = 1'b1;
    tick();
    i_ack = 1'b0;
    tick();
    tick();
    check("t4_wait_word1", {31'b0, snap_ready}, 32'h0);
    i_ack = 1'b1;
    tick();
    check("t4_word1_addr", snap_addr, 32'h4);
    i_ack = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("t4_sb_empty", sb.size(), 32'h0);

    // Test 5: redirect to 0x102 coinciding with an ack and a consume.
    fill_nops();
    img[64] = 32'h4505_0000; img[65] = 32'h0000_0013;
    do_reset();
    expect_out(32'h0, 32'h0000_0013, 1'b0);
    i_ack = 1'b1; i_decode_ready = 1'b1;
    tick(); tick();
    i_pc_select = 1'b1; i_pc_target = 32'h0000_0102;
    tick();
    check("t5_redir_ready", {31'b0, snap_ready}, 32'h0);
    check("t5_redir_cyc", {31'b0, snap_cyc}, 32'h0);
    i_pc_select = 1'b0;
    expect_out(32'h102, 32'h0000_4505, 1'b1);
    expect_out(32'h104, 32'h0000_0013, 1'b0);
    tick();
    check("t5_new_cyc", {31'b0, snap_cyc}, 32'h1);
    check("t5_new_addr", snap_addr, 32'h100);
    check("t5_empty_after_redirect", {31'b0, snap_ready}, 32'h0);
    tick();
    i_ack = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("t5_sb_empty", sb.size(), 32'h0);

    // Test 6: reset pulsed mid-cycle with a full queue and ack high.
    fill_nops();
    do_reset();
    i_ack = 1'b1; i_decode_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("t6_full_ready", {31'b0, snap_ready}, 32'h1);
    #2;
    i_reset = 1'b1;
    #1;
    check("t6_rst_cyc", {31'b0, o_cyc}, 32'h0);
    check("t6_rst_ready", {31'b0, o_ready}, 32'h0);
    check("t6_rst_addr", o_addr, 32'h0);
    check("t6_rst_pc", o_pc, 32'h0);
    check("t6_rst_instr", o_instruction, 32'h0);
    check("t6_rst_compressed", {31'b0, o_compressed}, 32'h0);
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_ack = 1'b0;
    tick();
    check("t6_restart_cyc", {31'b0, snap_cyc}, 32'h1);
    check("t6_restart_addr", snap_addr, 32'h0);
    check("t6_restart_ready", {31'b0, snap_ready}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
